ahb_sram_slave: RTL
===================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, HADDR width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, HWDATA/HRDATA width; only 32 supported.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, number of 32-bit words.
REQ-004 SHALL have parameter WAIT_STATES, default 2, range 0..7, data-phase wait cycles per transfer (used only with AHB_SRAM_WAIT_EN).
REQ-005 SHALL have port HCLK, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port HRESET, input, 1; one clock; reset is asynchronous and active-high.
REQ-007 SHALL have ports HSEL_SRAM (input, 1, decoder select) and HADDR (input, ADDR_WIDTH, byte address).
REQ-008 SHALL have ports HTRANS (input, 2), HWRITE (input, 1), HSIZE (input, 3), HBURST (input, 3, ignored), HPROT (input, 4, ignored).
REQ-009 SHALL have ports HWDATA (input, 32, write data) and HREADY (input, 1, bus-level ready).
REQ-010 SHALL have ports HRDATA (output, 32), HREADYOUT (output, 1, slave ready) and HRESP (output, 2; OKAY=00, ERROR=01).
REQ-011 SHALL have port HSPLIT, output, NO_OF_MASTERS bits, tied to zero (no RETRY/SPLIT issued).

Function
REQ-012 SHALL accept an address phase only when HSEL_SRAM=1, HREADY=1 and HTRANS is NONSEQ(10) or SEQ(11), and SHALL register HADDR, HWRITE and HSIZE.
REQ-013 SHALL treat IDLE(00), BUSY(01) or HSEL_SRAM=0 as no transfer: next cycle HREADYOUT=1, HRESP=OKAY, memory unchanged.
REQ-014 SHALL implement FSM states IDLE, WAIT, ERR1, ERR2; a valid transfer goes IDLE->WAIT (when wait count>0) or completes in IDLE.
REQ-015 SHALL flag an error transfer when word index HADDR[ADDR_WIDTH-1:2] >= MEM_DEPTH, HSIZE>2, or the address is misaligned for HSIZE (halfword with HADDR[0]=1; word with HADDR[1:0]!=0).
REQ-016 SHALL respond to an error transfer with two cycles: ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01), then IDLE; memory is never written.
REQ-017 SHALL write only the byte lanes selected by the registered HSIZE/HADDR[1:0] (byte: 1 lane; halfword: lanes [1:0] or [3:2]; word: all 4), using HWDATA sampled in the data-phase cycle where HREADYOUT=1.
REQ-018 SHALL drive HRDATA with the full addressed word in the final data-phase cycle (HREADYOUT=1) of a read; HRDATA is 0 in all other cycles.
REQ-019 SHALL forward data so a read whose address phase overlaps the data phase of a write to the same word returns the merged newly written bytes.
REQ-020 SHALL never change a pending data phase when new address-phase inputs arrive while HREADYOUT=0; those inputs are not sampled.
REQ-021 SHALL support back-to-back pipelined transfers with zero wait states: one transfer completes per cycle.

Reset
REQ-022 SHALL, while HRESET=1, force FSM to IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, HSPLIT=0, wait counter=0.
REQ-023 SHALL abort any in-progress data phase on reset without writing memory; memory contents are not cleared.

Configuration
REQ-024 SHALL, when AHB_SRAM_WAIT_EN is defined, hold HREADYOUT=0 for exactly WAIT_STATES cycles in WAIT before the completing cycle of every valid transfer.
REQ-025 SHALL, when AHB_SRAM_WAIT_EN is undefined, omit the wait counter and WAIT state; every valid transfer completes in the first data-phase cycle.
REQ-026 SHALL apply the two-cycle error response identically with or without AHB_SRAM_WAIT_EN (no wait states before ERR1).

Verification
REQ-027 SHALL verify: word write 0xDEADBEEF to 0x10, then read 0x10 -> HRDATA=0xDEADBEEF, HRESP=00.
REQ-028 SHALL verify: byte write 0xAA to 0x13 over word 0x11223344 -> subsequent read of 0x10 returns 0xAA223344.
REQ-029 SHALL verify: read of address 4*MEM_DEPTH (0x1000) -> ERR1 then ERR2, HRESP=01 both cycles, HREADYOUT 0 then 1.
REQ-030 SHALL verify: with AHB_SRAM_WAIT_EN and WAIT_STATES=2, read -> HREADYOUT low 2 cycles, high on 3rd with valid HRDATA.
REQ-031 SHALL verify: write 0x5 to 0x20 immediately followed by pipelined read of 0x20 -> read returns 0x00000005 (forwarding).
REQ-032 SHALL verify: HRESET asserted mid-WAIT of a write -> next cycle HREADYOUT=1, HRESP=00, target word unchanged.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB SRAM slave: byte-lane writes, two-cycle ERROR response, combinational read.
// Define AHB_SRAM_WAIT_EN to insert WAIT_STATES data-phase wait cycles per transfer.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH     = 1024,
    parameter int WAIT_STATES   = 2,
    parameter int NO_OF_MASTERS = 16
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     HSEL_SRAM,
    input  logic [ADDR_WIDTH-1:0]    HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [2:0]               HBURST,
    input  logic [3:0]               HPROT,
    input  logic [DATA_WIDTH-1:0]    HWDATA,
    input  logic                     HREADY,
    output logic [DATA_WIDTH-1:0]    HRDATA,
    output logic                     HREADYOUT,
    output logic [1:0]               HRESP,
    output logic [NO_OF_MASTERS-1:0] HSPLIT
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-3:0] DEPTH_L = (ADDR_WIDTH-2)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef AHB_SRAM_WAIT_EN
        S_WAIT = 2'd1,
`endif
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    state_t                  r_state, w_next;
    logic                    r_pend, r_write;
    logic [2:0]              r_size;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];
    logic                    w_accept, w_err, w_we;
    logic [3:0]              w_be;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_unused;

    assign w_accept = HSEL_SRAM && HREADY && HTRANS[1] && HREADYOUT;
    assign w_idx    = r_addr[IDX_W+1:2];
    assign w_we     = (r_state == S_IDLE) && r_pend && r_write;
    assign HSPLIT   = '0;
    assign w_unused = ^{HBURST, HPROT, HTRANS[0], r_addr, 3'(WAIT_STATES)};

    always_comb begin
        w_err = (HADDR[ADDR_WIDTH-1:2] >= DEPTH_L) || (HSIZE > 3'd2);
        if (HSIZE == 3'd1 && HADDR[0])
            w_err = 1'b1;
        if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
            w_err = 1'b1;
    end

`ifdef AHB_SRAM_WAIT_EN
    logic [2:0] r_cnt;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            r_cnt <= 3'd0;
        else if (w_accept && !w_err)
            r_cnt <= 3'(WAIT_STATES);
        else if (r_state == S_WAIT)
            r_cnt <= r_cnt - 3'd1;
    end
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ERR1: w_next = S_ERR2;
`ifdef AHB_SRAM_WAIT_EN
            S_WAIT: if (r_cnt == 3'd1) w_next = S_IDLE;
`endif
            default: begin
                // IDLE and ERR2 both drive HREADYOUT=1, so either may take a new address phase
                w_next = S_IDLE;
                if (w_accept) begin
                    if (w_err)
                        w_next = S_ERR1;
`ifdef AHB_SRAM_WAIT_EN
                    else if (WAIT_STATES != 0)
                        w_next = S_WAIT;
`endif
                end
            end
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 2'b00;
        HRDATA    = '0;
        case (r_state)
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 2'b01;
            end
            S_ERR2: HRESP = 2'b01;
`ifdef AHB_SRAM_WAIT_EN
            S_WAIT: HREADYOUT = 1'b0;
`endif
            default: if (r_pend && !r_write) HRDATA = r_mem[w_idx];
        endcase
    end

    // Address-phase capture; inputs are ignored while the slave stalls the bus
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_pend  <= 1'b0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
            r_addr  <= '0;
        end else if (w_accept) begin
            r_pend  <= !w_err;
            r_write <= HWRITE;
            r_size  <= HSIZE;
            r_addr  <= HADDR;
        end else if (HREADYOUT) begin
            r_pend  <= 1'b0;
        end
    end

    always_comb begin
        case (r_size)
            3'd0:    w_be = 4'b0001 << r_addr[1:0];
            3'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Write lands at the end of the completing cycle, so a read accepted in that same
    // cycle sees the merged word through the combinational read port next cycle.
    always_ff @(posedge HCLK) begin
        if (w_we)
            for (int i = 0; i < 4; i++)
                if (w_be[i])
                    r_mem[w_idx][8*i +: 8] <= HWDATA[8*i +: 8];
    end
endmodule
